// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and lane helpers for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Picks the addressed byte/half out of a word and extends it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                               input size_e size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    lane_extract = {{24{b[7] & ~uns}}, b};
      SZ_H:    lane_extract = {{16{h[15] & ~uns}}, h};
      default: lane_extract = word;
    endcase
  endfunction

  // Replaces the addressed lane(s) of word with the right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] off, input size_e size);
    lane_merge = data;
    case (size)
      SZ_B: begin
        case (off)
          2'd0:    lane_merge = {word[31:8], data[7:0]};
          2'd1:    lane_merge = {word[31:16], data[7:0], word[7:0]};
          2'd2:    lane_merge = {word[31:24], data[7:0], word[15:0]};
          default: lane_merge = {data[7:0], word[23:0]};
        endcase
      end
      SZ_H:    lane_merge = off[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
      default: lane_merge = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - combinational lane extract/merge around the package helpers
module mem_lane
  import mem_arb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  assign extracted = lane_extract(word, off, size_e'(size), uns);
  assign merged    = lane_merge(word, data, off, size_e'(size));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin sequencer for the single-port word memory
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [31:0]       r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic              r0_write,
  input  logic [1:0]        r0_size,
  input  logic              r0_unsigned,
  output logic              r0_rvalid,
  output logic [31:0]       r0_rdata,
  output logic              r0_err,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [31:0]       r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic              r1_write,
  input  logic [1:0]        r1_size,
  input  logic              r1_unsigned,
  output logic              r1_rvalid,
  output logic [31:0]       r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e            state_q, state_d;
  logic              last_q;
  logic              port_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  size_e             size_q;
  logic              uns_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merged_q;

  logic        grant0, grant1, accept;
  logic [31:0] sel_addr;
  size_e       sel_size;
  logic        sel_misalign, sel_oob, req_err;
  logic [31:0] lane_extracted, lane_merged;

  assign sel_addr = grant1 ? r1_addr : r0_addr;
  assign sel_size = size_e'(grant1 ? r1_size : r0_size);
  assign accept   = grant0 | grant1;

  always_comb begin
    sel_misalign = 1'b0;
    case (sel_size)
      SZ_H:    sel_misalign = sel_addr[0];
      SZ_W:    sel_misalign = (sel_addr[1:0] != 2'b00);
      SZ_RSV:  sel_misalign = 1'b1;
      default: sel_misalign = 1'b0;
    endcase
  end

  assign sel_oob = ({2'b00, sel_addr[31:2]} >= DEPTH_W);
  assign req_err = sel_misalign | sel_oob;

  mem_lane u_lane (
    .word      (mem_rdata),
    .data      (wdata_q),
    .off       (addr_q[1:0]),
    .size      (size_q),
    .uns       (uns_q),
    .extracted (lane_extracted),
    .merged    (lane_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grants, memory strobes and the next state all decode from state_q, so reset kills them at once.
  always_comb begin
    state_d   = state_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        grant0 = r0_valid & (~r1_valid | last_q);
        grant1 = r1_valid & (~r0_valid | ~last_q);
        if (grant0 | grant1) state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (write_q && size_q == SZ_W) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
          state_d   = RESP;
        end else if (write_q) begin
          state_d = MERGE;
        end else begin
          state_d = RESP;
        end
      end
      MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merged_q;
        state_d   = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      write_q  <= 1'b0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      merged_q <= 32'h0;
    end else begin
      if (state_q == IDLE && accept) begin
        last_q  <= grant1;
        port_q  <= grant1;
        addr_q  <= sel_addr[ADDR_W+1:0];
        wdata_q <= grant1 ? r1_wdata : r0_wdata;
        write_q <= grant1 ? r1_write : r0_write;
        size_q  <= sel_size;
        uns_q   <= grant1 ? r1_unsigned : r0_unsigned;
        err_q   <= req_err;
        rdata_q <= 32'h0;
      end
      if (state_q == ACCESS && !write_q) rdata_q <= lane_extracted;
      if (state_q == ACCESS && write_q)  merged_q <= lane_merged;
    end
  end

  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign r0_ready  = grant0;
  assign r1_ready  = grant1;
  assign r0_rvalid = (state_q == RESP) & ~port_q;
  assign r1_rvalid = (state_q == RESP) & port_q;
  assign r0_err    = r0_rvalid & err_q;
  assign r1_err    = r1_rvalid & err_q;
  assign r0_rdata  = r0_rvalid ? rdata_q : 32'h0;
  assign r1_rdata  = r1_rvalid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r0_write, r0_unsigned, r0_rvalid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic [1:0]  r0_size;
  logic        r1_valid, r1_ready, r1_write, r1_unsigned, r1_rvalid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [1:0]  r1_size;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] tb_mem [0:8191];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int rv1_cnt  = 0;
  int rdy1_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(8192), .ADDR_W(13)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_write(r0_write), .r0_size(r0_size), .r0_unsigned(r0_unsigned),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_write(r1_write), .r1_size(r1_size), .r1_unsigned(r1_unsigned),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  always @(negedge clk) begin
    if (mem_we)    we_cnt++;
    if (r1_rvalid) rv1_cnt++;
    if (r1_ready)  rdy1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit wr, input logic [1:0] sz, input bit uns, input bit vld);
    if (port) begin
      r1_addr = addr; r1_wdata = wdata; r1_write = wr; r1_size = sz; r1_unsigned = uns; r1_valid = vld;
    end else begin
      r0_addr = addr; r0_wdata = wdata; r0_write = wr; r0_size = sz; r0_unsigned = uns; r0_valid = vld;
    end
  endtask

  // One request on one port; lat counts negedges from the accept edge to the rvalid cycle.
  task automatic do_req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit wr, input logic [1:0] sz, input bit uns,
                        output int lat, output logic [31:0] rd, output logic er, output int wed);
    int  we0;
    bit  got;
    we0 = we_cnt;
    got = 1'b0;
    lat = -1; rd = 32'hx; er = 1'bx;
    drive(port, addr, wdata, wr, sz, uns, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? r1_ready : r0_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    drive(port, addr, wdata, wr, sz, uns, 1'b0);
    if (got) begin
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (port ? r1_rvalid : r0_rvalid) begin
          lat = i; rd = port ? r1_rdata : r0_rdata; er = port ? r1_err : r0_err;
          break;
        end
      end
    end
    wed = we_cnt - we0;
  endtask

  int          lat, wed, n, m, c0;
  logic [31:0] rd;
  logic        er;
  bit          got;
  int          g [6];
  int          rv [6];
  logic [31:0] rdv [6];
  logic [31:0] e_addr [5];
  logic [1:0]  e_size [5];
  bit          e_wr [5];
  bit          e_port [5];

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 8192; i++) tb_mem[i] = 32'h0;
    tb_mem[32'h80] = 32'hA0A0A0A0;
    tb_mem[32'hC0] = 32'hB1B1B1B1;
    repeat (2) @(negedge clk);
    check("reset_r0_ready", {31'b0, r0_ready}, 32'd0);
    check("reset_r1_ready", {31'b0, r1_ready}, 32'd0);
    check("reset_rvalid", {30'b0, r0_rvalid, r1_rvalid}, 32'd0);
    check("reset_err", {30'b0, r0_err, r1_err}, 32'd0);
    check("reset_mem_we", {31'b0, mem_we}, 32'd0);
    check("reset_mem_addr", {19'b0, mem_addr}, 32'd0);
    check("reset_rdata", r0_rdata | r1_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Both ports continuously valid: grants must alternate starting at port 0.
    for (int i = 0; i < 6; i++) begin g[i] = -1; rv[i] = -1; rdv[i] = 32'hx; end
    drive(1'b0, 32'h200, 32'h0, 1'b0, 2'b10, 1'b0, 1'b1);
    drive(1'b1, 32'h300, 32'h0, 1'b0, 2'b10, 1'b0, 1'b1);
    n = 0; m = 0; c0 = 0;
    for (int c = 0; c < 60 && m < 6; c++) begin
      @(negedge clk);
      if (r0_ready && r1_ready) c0++;
      if (r0_rvalid) begin rv[m] = 0; rdv[m] = r0_rdata; m++; end
      else if (r1_rvalid) begin rv[m] = 1; rdv[m] = r1_rdata; m++; end
      if (n < 6 && (r0_ready || r1_ready)) begin
        g[n] = r1_ready ? 1 : 0;
        n++;
        if (n == 6) begin @(posedge clk); #1; r0_valid = 1'b0; r1_valid = 1'b0; end
      end
    end
    check("arb_both_ready", c0, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("arb_grant%0d", i), g[i], i % 2);
      check($sformatf("arb_rvalid_port%0d", i), rv[i], i % 2);
      check($sformatf("arb_rdata%0d", i), rdv[i], (i % 2) ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
    end

    do_req(1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, lat, rd, er, wed);
    check("wst_lat", lat, 2);
    check("wst_err", {31'b0, er}, 32'd0);
    check("wst_rdata", rd, 32'd0);
    check("wst_we_cycles", wed, 1);
    check("wst_mem", tb_mem[32'h40], 32'hDEADBEEF);

    do_req(1'b0, 32'h100, 32'h0, 1'b0, 2'b10, 1'b0, lat, rd, er, wed);
    check("wld_lat", lat, 2);
    check("wld_rdata", rd, 32'hDEADBEEF);
    check("wld_err", {31'b0, er}, 32'd0);
    check("wld_we_cycles", wed, 0);

    tb_mem[32'h40] = 32'h11223344;
    do_req(1'b0, 32'h102, 32'h0000007F, 1'b1, 2'b00, 1'b0, lat, rd, er, wed);
    check("bst_lat", lat, 3);
    check("bst_mem", tb_mem[32'h40], 32'h117F3344);
    check("bst_we_cycles", wed, 1);

    tb_mem[32'h40] = 32'h80123456;
    do_req(1'b0, 32'h103, 32'h0, 1'b0, 2'b00, 1'b0, lat, rd, er, wed);
    check("bld_s_lat", lat, 2);
    check("bld_s_rdata", rd, 32'hFFFFFF80);
    do_req(1'b0, 32'h103, 32'h0, 1'b0, 2'b00, 1'b1, lat, rd, er, wed);
    check("bld_u_rdata", rd, 32'h00000080);
    do_req(1'b1, 32'h102, 32'h0, 1'b0, 2'b01, 1'b0, lat, rd, er, wed);
    check("hld_s_rdata", rd, 32'hFFFF8012);
    do_req(1'b0, 32'h100, 32'h0, 1'b0, 2'b01, 1'b1, lat, rd, er, wed);
    check("hld_u_rdata", rd, 32'h00003456);
    do_req(1'b1, 32'h100, 32'h0000CAFE, 1'b1, 2'b01, 1'b0, lat, rd, er, wed);
    check("hst_lat", lat, 3);
    check("hst_mem", tb_mem[32'h40], 32'h8012CAFE);

    e_addr = '{32'h101, 32'h102, 32'h100, 32'h8000, 32'h8001};
    e_size = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
    e_wr   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    e_port = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_req(e_port[i], e_addr[i], 32'h55555555, e_wr[i], e_size[i], 1'b0, lat, rd, er, wed);
      check($sformatf("err%0d_lat", i), lat, 1);
      check($sformatf("err%0d_err", i), {31'b0, er}, 32'd1);
      check($sformatf("err%0d_rdata", i), rd, 32'd0);
      check($sformatf("err%0d_we_cycles", i), wed, 0);
    end
    check("err_mem_untouched", tb_mem[32'h40], 32'h8012CAFE);

    do_req(1'b0, 32'h7FFC, 32'h12345678, 1'b1, 2'b10, 1'b0, lat, rd, er, wed);
    check("last_word_lat", lat, 2);
    check("last_word_err", {31'b0, er}, 32'd0);
    check("last_word_mem", tb_mem[8191], 32'h12345678);

    // Port 1 raises and withdraws a request while port 0 owns the memory.
    tb_mem[32'h60] = 32'h0;
    n = rv1_cnt; m = rdy1_cnt; got = 1'b0;
    drive(1'b0, 32'h181, 32'h0000005A, 1'b1, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0_ready) begin got = 1'b1; break; end
    end
    check("wd_accept", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    drive(1'b1, 32'h300, 32'h0, 1'b0, 2'b10, 1'b0, 1'b1);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    lat = -1;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      if (r0_rvalid) begin lat = i; break; end
    end
    repeat (6) @(negedge clk);
    check("wd_p0_lat", lat, 3);
    check("wd_p0_mem", tb_mem[32'h60], 32'h00005A00);
    check("wd_p1_no_resp", rv1_cnt - n, 0);
    check("wd_p1_no_grant", rdy1_cnt - m, 0);

    // Asynchronous reset in the MERGE cycle of a byte store.
    tb_mem[32'h50] = 32'hAABBCCDD;
    @(posedge clk); #1;
    drive(1'b0, 32'h140, 32'h00000011, 1'b1, 2'b00, 1'b0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_merge_we", {31'b0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_we_drop", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check("rst_mem_unchanged", tb_mem[32'h50], 32'hAABBCCDD);
    check("rst_no_rvalid", {31'b0, r0_rvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h140, 32'h0, 1'b0, 2'b10, 1'b0, 1'b1);
    drive(1'b1, 32'h300, 32'h0, 1'b0, 2'b10, 1'b0, 1'b1);
    #1;
    check("post_rst_r0_ready", {31'b0, r0_ready}, 32'd1);
    check("post_rst_r1_ready", {31'b0, r1_ready}, 32'd0);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    lat = -1; rd = 32'hx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (r0_rvalid) begin lat = i; rd = r0_rdata; break; end
    end
    check("post_rst_lat", lat, 2);
    check("post_rst_rdata", rd, 32'hAABBCCDD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
